// File: rtl/pcm_moving_average_pkg.sv
// Shared definitions for the PCM moving-average block.
//   - default PCM word width and window size
//   - accumulator width helper (sample width plus window growth)
//   - fill state of the window (FILLING until the window first fills, then FULL)
//   - stereo frame typedef {left, right}
package pcm_moving_average_pkg;

  localparam int PCM_BITS_DEFAULT    = 8;
  localparam int LOG2_WINDOW_DEFAULT = 3;

  typedef enum logic {
    FILLING = 1'b0,
    FULL    = 1'b1
  } fill_state_e;

  typedef struct packed {
    logic [PCM_BITS_DEFAULT-1:0] left;
    logic [PCM_BITS_DEFAULT-1:0] right;
  } pcm_frame_t;

  // A sum of 2**log2_window signed nbits-wide samples needs log2_window extra
  // bits, so the running sum can never overflow.
  function automatic int acc_width(input int nbits, input int log2_window);
    return nbits + log2_window;
  endfunction

endpackage

// File: rtl/pcm_ring_channel.sv
// One channel of the moving average: ring storage of the last 2**LOG2_WINDOW
// samples plus a signed running sum.
// Ports:
//   clk, reset     clock, asynchronous active-high reset (clears the sum only)
//   clear          synchronous flush of the running sum
//   push           accept sample_in this cycle (already qualified by the top)
//   evict          window is full: the slot at wr_ptr holds the oldest sample
//   wr_ptr         ring slot to overwrite, owned by the top
//   sample_in      new signed PCM sample
//   sum_next       running sum including sample_in (combinational)
module pcm_ring_channel
  import pcm_moving_average_pkg::*;
#(
  parameter int NUMBER_OF_BITS = PCM_BITS_DEFAULT,
  parameter int LOG2_WINDOW    = LOG2_WINDOW_DEFAULT,
  localparam int ACC_W         = acc_width(NUMBER_OF_BITS, LOG2_WINDOW)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      push,
  input  logic                      evict,
  input  logic [LOG2_WINDOW-1:0]    wr_ptr,
  input  logic [NUMBER_OF_BITS-1:0] sample_in,
  output logic [ACC_W-1:0]          sum_next
);

  localparam int DEPTH = 2 ** LOG2_WINDOW;

  logic [NUMBER_OF_BITS-1:0] ring [DEPTH];
  logic signed [ACC_W-1:0]   sum_q;
  logic signed [ACC_W-1:0]   new_ext;
  logic signed [ACC_W-1:0]   old_ext;

  // While filling, ring slots hold stale data; treat them as zero so the
  // average of a partial window is sum / window.
  always_comb begin
    new_ext  = ACC_W'($signed(sample_in));
    old_ext  = evict ? ACC_W'($signed(ring[wr_ptr])) : '0;
    sum_next = sum_q + new_ext - old_ext;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q <= '0;
    end else if (clear) begin
      sum_q <= '0;
    end else if (push) begin
      sum_q <= sum_next;
    end
  end

  // Storage is intentionally not reset; evict masks it until the window fills.
  always_ff @(posedge clk) begin
    if (push) begin
      ring[wr_ptr] <= sample_in;
    end
  end

endmodule

// File: rtl/pcm_moving_average.sv
// Per-channel moving average over the last 2**LOG2_WINDOW stereo PCM frames.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   clear               synchronous flush, identical in effect to reset
//   sample_valid        one-cycle strobe, left_in/right_in carry a new frame
//   left_in, right_in   signed PCM samples
//   avg_left/avg_right  registered floor(sum / window) per channel
//   avg_valid           one-cycle strobe, avg_* updated this cycle
//   window_full         window state (FULL once a full window has been accepted)
// Handshake: sample_valid is a pure strobe with no back-pressure; every strobe
// not coinciding with clear is accepted and answered by exactly one avg_valid
// pulse on the following cycle. clear wins over sample_valid.
module pcm_moving_average
  import pcm_moving_average_pkg::*;
#(
  parameter int NUMBER_OF_BITS = PCM_BITS_DEFAULT,
  parameter int LOG2_WINDOW    = LOG2_WINDOW_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      sample_valid,
  input  logic [NUMBER_OF_BITS-1:0] left_in,
  input  logic [NUMBER_OF_BITS-1:0] right_in,
  output logic [NUMBER_OF_BITS-1:0] avg_left,
  output logic [NUMBER_OF_BITS-1:0] avg_right,
  output logic                      avg_valid,
  output logic                      window_full
);

  localparam int ACC_W = acc_width(NUMBER_OF_BITS, LOG2_WINDOW);
  localparam int DEPTH = 2 ** LOG2_WINDOW;
  localparam logic [LOG2_WINDOW:0] FILL_MAX  = (LOG2_WINDOW + 1)'(DEPTH);
  localparam logic [LOG2_WINDOW:0] FILL_LAST = (LOG2_WINDOW + 1)'(DEPTH - 1);

  logic                   accept;
  logic [LOG2_WINDOW-1:0] wr_ptr;
  logic [LOG2_WINDOW:0]   fill_count;
  fill_state_e            state;
  logic [ACC_W-1:0]       sum_next_l;
  logic [ACC_W-1:0]       sum_next_r;

  assign accept      = sample_valid & ~clear;
  assign window_full = (state == FULL);

  pcm_ring_channel #(
    .NUMBER_OF_BITS(NUMBER_OF_BITS),
    .LOG2_WINDOW   (LOG2_WINDOW)
  ) u_left (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .push     (accept),
    .evict    (window_full),
    .wr_ptr   (wr_ptr),
    .sample_in(left_in),
    .sum_next (sum_next_l)
  );

  pcm_ring_channel #(
    .NUMBER_OF_BITS(NUMBER_OF_BITS),
    .LOG2_WINDOW   (LOG2_WINDOW)
  ) u_right (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .push     (accept),
    .evict    (window_full),
    .wr_ptr   (wr_ptr),
    .sample_in(right_in),
    .sum_next (sum_next_r)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      fill_count <= '0;
      state      <= FILLING;
      avg_left   <= '0;
      avg_right  <= '0;
      avg_valid  <= 1'b0;
    end else if (clear) begin
      wr_ptr     <= '0;
      fill_count <= '0;
      state      <= FILLING;
      avg_left   <= '0;
      avg_right  <= '0;
      avg_valid  <= 1'b0;
    end else begin
      avg_valid <= accept;
      if (accept) begin
        // Window is a power of two, so the pointer wraps naturally.
        wr_ptr <= wr_ptr + 1'b1;
        if (fill_count != FILL_MAX) begin
          fill_count <= fill_count + 1'b1;
        end
        if (state == FILLING && fill_count == FILL_LAST) begin
          state <= FULL;
        end
        // Taking the upper bits is an arithmetic shift right by LOG2_WINDOW
        // (floor toward -inf); the result always fits the PCM width.
        avg_left  <= sum_next_l[ACC_W-1:LOG2_WINDOW];
        avg_right <= sum_next_r[ACC_W-1:LOG2_WINDOW];
      end
    end
  end

endmodule

// File: tb/tb_pcm_moving_average.sv
module tb_pcm_moving_average;
  import pcm_moving_average_pkg::*;

  localparam int NB = 8;
  localparam int LW = 3;
  localparam int W  = 2 ** LW;

  logic          clk;
  logic          reset;
  logic          clear;
  logic          sample_valid;
  logic [NB-1:0] left_in;
  logic [NB-1:0] right_in;
  logic [NB-1:0] avg_left;
  logic [NB-1:0] avg_right;
  logic          avg_valid;
  logic          window_full;

  pcm_moving_average #(.NUMBER_OF_BITS(NB), .LOG2_WINDOW(LW)) dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .sample_valid(sample_valid),
    .left_in     (left_in),
    .right_in    (right_in),
    .avg_left    (avg_left),
    .avg_right   (avg_right),
    .avg_valid   (avg_valid),
    .window_full (window_full)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic          v;
    logic          full;
    logic [NB-1:0] l;
    logic [NB-1:0] r;
  } exp_t;

  exp_t exp_q[$];
  int   ql[$];
  int   qr[$];
  logic [NB-1:0] last_l = '0;
  logic [NB-1:0] last_r = '0;

  int n_vec       = 0;
  int n_err       = 0;
  int n_strobe    = 0;
  int n_dut_valid = 0;
  bit check_en    = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // floor(s / W), rounding toward minus infinity
  function automatic int fdiv(input int s);
    if (s >= 0) return s / W;
    return -((-s + W - 1) / W);
  endfunction

  function automatic int win_avg(input int q[$]);
    int s;
    s = 0;
    foreach (q[i]) s += q[i];
    return fdiv(s);
  endfunction

  // ---------------- driver ----------------
  // Applies one cycle of stimulus at the falling edge and records what the
  // outputs must show after the following rising edge.
  task automatic drive(input bit v, input bit c, input int l, input int r,
                       input bit rs = 1'b0);
    exp_t e;
    @(negedge clk);
    reset        = rs;
    clear        = c;
    sample_valid = v;
    left_in      = NB'(l);
    right_in     = NB'(r);
    e = '0;
    if (rs || c) begin
      ql.delete();
      qr.delete();
      last_l = '0;
      last_r = '0;
    end else if (v) begin
      ql.push_back(int'($signed(left_in)));
      qr.push_back(int'($signed(right_in)));
      if (ql.size() > W) void'(ql.pop_front());
      if (qr.size() > W) void'(qr.pop_front());
      last_l = NB'(win_avg(ql));
      last_r = NB'(win_avg(qr));
      e.v = 1'b1;
      n_strobe++;
    end
    e.l    = last_l;
    e.r    = last_r;
    e.full = (ql.size() == W);
    exp_q.push_back(e);
  endtask

  // Asynchronous reset raised between clock edges; outputs must clear at once.
  task automatic async_reset();
    exp_t e;
    @(negedge clk);
    #2;
    reset        = 1'b1;
    clear        = 1'b0;
    sample_valid = 1'b0;
    ql.delete();
    qr.delete();
    last_l = '0;
    last_r = '0;
    e = '0;
    exp_q.push_back(e);
    #1;
    chk("async_rst_avg_left", int'($signed(avg_left)), 0);
    chk("async_rst_avg_right", int'($signed(avg_right)), 0);
    chk("async_rst_avg_valid", int'(avg_valid), 0);
    chk("async_rst_window_full", int'(window_full), 0);
    drive(0, 0, 0, 0, 1);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // ---------------- compare process ----------------
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (check_en && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("avg_valid", int'(avg_valid), int'(e.v));
      chk("window_full", int'(window_full), int'(e.full));
      chk("avg_left", int'($signed(avg_left)), int'($signed(e.l)));
      chk("avg_right", int'($signed(avg_right)), int'($signed(e.r)));
      if (avg_valid) n_dut_valid++;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    pcm_frame_t pat[W];
    int s0, d0;

    reset        = 1'b1;
    clear        = 1'b0;
    sample_valid = 1'b0;
    left_in      = '0;
    right_in     = '0;
    repeat (3) @(posedge clk);
    #2;
    // 1: reset state
    chk("reset_avg_left", int'($signed(avg_left)), 0);
    chk("reset_avg_right", int'($signed(avg_right)), 0);
    chk("reset_avg_valid", int'(avg_valid), 0);
    chk("reset_window_full", int'(window_full), 0);
    check_en = 1'b1;

    // 2: fill with 16 / -16
    drive(1, 0, 16, -16);
    settle();
    chk("fill_first_left", int'($signed(avg_left)), 2);
    chk("fill_first_right", int'($signed(avg_right)), -2);
    chk("fill_first_not_full", int'(window_full), 0);
    for (int i = 1; i < W; i++) drive(1, 0, 16, -16);
    settle();
    chk("fill_last_left", int'($signed(avg_left)), 16);
    chk("fill_last_right", int'($signed(avg_right)), -16);
    chk("fill_last_full", int'(window_full), 1);

    // 3: steady state across pointer wrap, one idle gap for the hold check
    drive(1, 0, 0, 0);
    settle();
    chk("wrap_first_left", int'($signed(avg_left)), 14);
    drive(0, 0, 99, 99);
    settle();
    chk("hold_left", int'($signed(avg_left)), 14);
    chk("hold_valid", int'(avg_valid), 0);
    for (int i = 1; i < W; i++) drive(1, 0, 0, 0);
    settle();
    chk("wrap_last_left", int'($signed(avg_left)), 0);
    chk("wrap_last_right", int'($signed(avg_right)), 0);

    // 4: extremes
    for (int i = 0; i < W; i++) drive(1, 0, 127, -128);
    settle();
    chk("ext_left", int'($signed(avg_left)), 127);
    chk("ext_right", int'($signed(avg_right)), -128);
    drive(1, 0, 0, 0);
    settle();
    chk("ext_evict_left", int'($signed(avg_left)), 111);
    chk("ext_evict_right", int'($signed(avg_right)), -112);

    // 6: clear collides with a sample while the window is full
    drive(1, 1, 50, 50);
    settle();
    chk("clr_valid", int'(avg_valid), 0);
    chk("clr_full", int'(window_full), 0);
    drive(1, 0, 8, 8);
    settle();
    chk("clr_next_left", int'($signed(avg_left)), 1);

    // reset mid-window, then a fresh fill
    drive(1, 0, 100, -100);
    drive(1, 0, 100, -100);
    async_reset();
    drive(1, 0, 40, -40);
    settle();
    chk("post_rst_left", int'($signed(avg_left)), 5);
    chk("post_rst_right", int'($signed(avg_right)), -5);

    // 5: same frames back-to-back and with random gaps
    foreach (pat[i]) begin
      pat[i].left  = NB'($urandom_range(0, 255));
      pat[i].right = NB'($urandom_range(0, 255));
    end
    drive(0, 1, 0, 0);
    s0 = n_strobe;
    d0 = n_dut_valid;
    foreach (pat[i]) drive(1, 0, int'(pat[i].left), int'(pat[i].right));
    settle();
    chk("b2b_valid_count", n_dut_valid - d0, n_strobe - s0);
    drive(0, 1, 0, 0);
    s0 = n_strobe;
    d0 = n_dut_valid;
    foreach (pat[i]) begin
      drive(1, 0, int'(pat[i].left), int'(pat[i].right));
      repeat ($urandom_range(0, 3)) drive(0, 0, $urandom_range(0, 255), 0);
    end
    settle();
    chk("sparse_valid_count", n_dut_valid - d0, n_strobe - s0);

    // randomized traffic with occasional clears
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0,
            $urandom_range(0, 255), $urandom_range(0, 255));
    end
    drive(0, 0, 0, 0);
    settle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
